phy_regfile_read_arbiter: RTL and testbench
===========================================

// Module: phy_regfile_read_arbiter
// PURPOSE
//  Shares the physical register file's two synchronous read ports among NUM_REQ issue-queue requesters
//  (ALU, LSU, branch) between the IDU/rename stage and the execution units.
//  Each grant reads both source operands (rs1, rs2) of one instruction. Arbitration is round-robin.
//  Operands return one cycle later, tagged with the ROB tag. Same-cycle writeback data is forwarded.
// PARAMETERS
//  NUM_REQ      3                          number of requesters (>=2)
//  PREG_W       `PHYSICAL_REG_NUM_WIDTH    physical register index width
//  DATA_W       `REG_VAL_WIDTH             register value width
//  TAG_W        `ROB_SIZE_WIDTH            ROB tag width
// PORTS
//  clk           in   1               clock, all state on rising edge
//  rst_n         in   1               asynchronous reset, active-low
//  flush         in   1               ROB flush; kills the in-flight read
//  req_valid     in   NUM_REQ         requester i has an instruction ready to read operands
//  req_rs1       in   NUM_REQ*PREG_W  per-requester source-1 physical reg
//  req_rs2       in   NUM_REQ*PREG_W  per-requester source-2 physical reg
//  req_tag       in   NUM_REQ*TAG_W   per-requester ROB tag
//  req_ready     out  NUM_REQ         one-hot grant; request is consumed this cycle
//  rf_rd_addr1   out  PREG_W          regfile read port 1 address
//  rf_rd_addr2   out  PREG_W          regfile read port 2 address
//  rf_rd_data1   in   DATA_W          regfile port 1 data, valid the cycle after the address
//  rf_rd_data2   in   DATA_W          regfile port 2 data, valid the cycle after the address
//  wb_valid      in   1               writeback to regfile this cycle
//  wb_addr       in   PREG_W          writeback physical reg
//  wb_data       in   DATA_W          writeback value
//  resp_valid    out  1               operand response valid (single-cycle pulse)
//  resp_id       out  $clog2(NUM_REQ) index of the requester being served
//  resp_tag      out  TAG_W           ROB tag of the served instruction
//  resp_data1    out  DATA_W          rs1 value
//  resp_data2    out  DATA_W          rs2 value
// BEHAVIOUR
//  - Reset: rr_ptr=0, s1_valid=0; resp_valid=0, resp_id=0, resp_tag=0, resp_data*=0. req_ready is 0 while rst_n=0.
//  - Stage 0 (cycle T), combinational:
//      Winner = first i with req_valid[i], scanning from rr_ptr upward with wrap.
//      req_ready[winner]=1, all other bits 0; req_ready=0 when no request or when flush=1.
//      rf_rd_addr1/2 = winner's rs1/rs2; they are 0 when there is no grant.
//  - Handshake: a requester holds valid/rs/tag stable until it sees req_ready. Grant implies acceptance; no back-pressure on the response.
//  - rr_ptr update: on grant, rr_ptr <= (winner+1) mod NUM_REQ; with no grant it holds. No requester waits more than NUM_REQ-1 grants.
//  - Stage-1 register (edge ending T): s1_valid, s1_id, s1_tag, s1_rs1, s1_rs2.
//      Forward flags fwd1/fwd2 are set when wb_valid && wb_addr==rsX && rsX!=0, and fwd_data is captured.
//      Reason: the regfile reads old data on a same-cycle write.
//  - Stage 1 (cycle T+1), combinational outputs:
//      resp_valid = s1_valid & ~flush.
//      resp_dataX priority: (1) 0 if s1_rsX==0; (2) wb_data if wb_valid && wb_addr==s1_rsX; (3) fwd_data if fwdX; (4) rf_rd_dataX.
//      resp_id/resp_tag come from s1. When resp_valid=0, the data/id/tag outputs are don't-care and the bench must not check them.
//  - Latency: exactly 1 cycle from grant to resp_valid. Throughput: one instruction per cycle.
//  - flush at T: no grant at T, and s1_valid<=0. flush at T+1 suppresses resp_valid for the in-flight read. rr_ptr is unchanged by flush.
//  - rs1==rs2: both ports read the same reg, and the forwarding rules apply to each independently.
//  - Reset mid-operation: s1 is cleared at once and no response emerges.
//    Requesters must re-present their requests; a dropped grant is their concern.
// STRUCTURE
//  - Package phy_rf_arb_pkg: typedef preg_t, tag_t, data_t; rd_req_t struct {rs1, rs2, tag}; localparam ID_W=$clog2(NUM_REQ).
//  - Sub-module rr_arbiter #(N): req vector + ptr -> one-hot grant + index.
//    It is pure combinational; the parent owns rr_ptr.
//  - Top: rr_arbiter instance, address mux, stage-1 register, forwarding mux.
// TESTING
//  1. Reset release, no requests: req_ready=0, resp_valid=0, rf_rd_addr*=0 for 10 cycles.
//  2. Only req0 valid (rs1=5, rs2=9, tag=3), rf returns 0xA/0xB:
//     req_ready=001 at T; at T+1 resp_valid=1, id=0, tag=3, data=0xA/0xB.
//  3. All 3 valid continuously: grants cycle 001,010,100,001,...; each id is served once per 3 cycles.
//  4. Grant rs1=7 while wb_valid, wb_addr=7, wb_data=0x55, and rf returns the stale 0x11: resp_data1=0x55.
//     Separately, a wb to 7 at T+1 with data 0x66 gives resp_data1=0x66.
//  5. rs1=0, rs2=0 with wb to p0: resp_data1=resp_data2=0.
//  6. Grant at T, flush at T+1: resp_valid=0. Flush at T with req valid: req_ready=0 and rr_ptr unchanged.

Source files
------------

// File: rtl/phy_rf_arb_pkg.sv
// Shared types and default widths for the physical register file
// read-port arbiter.
package phy_rf_arb_pkg;

    localparam int NUM_REQ_D = 3;
    localparam int PREG_W_D  = 6;
    localparam int DATA_W_D  = 32;
    localparam int TAG_W_D   = 5;
    localparam int ID_W      = $clog2(NUM_REQ_D);

    typedef logic [PREG_W_D-1:0] preg_t;
    typedef logic [TAG_W_D-1:0]  tag_t;
    typedef logic [DATA_W_D-1:0] data_t;

    typedef struct packed {
        preg_t rs1;
        preg_t rs2;
        tag_t  tag;
    } rd_req_t;

endpackage

// File: rtl/phy_regfile_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or
// above ptr, with wrap-around. The parent owns the pointer.
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/phy_regfile_read_arbiter.sv
// Shares the two regfile read ports among NUM_REQ requesters, round-robin,
// with one-cycle operand return and writeback forwarding.
module phy_regfile_read_arbiter
    import phy_rf_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    parameter int PREG_W  = PREG_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int TAG_W   = TAG_W_D,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*PREG_W-1:0] req_rs1,
    input  logic [NUM_REQ*PREG_W-1:0] req_rs2,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [PREG_W-1:0]         rf_rd_addr1,
    output logic [PREG_W-1:0]         rf_rd_addr2,
    input  logic [DATA_W-1:0]         rf_rd_data1,
    input  logic [DATA_W-1:0]         rf_rd_data2,
    input  logic                      wb_valid,
    input  logic [PREG_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      resp_valid,
    output logic [IW-1:0]             resp_id,
    output logic [TAG_W-1:0]          resp_tag,
    output logic [DATA_W-1:0]         resp_data1,
    output logic [DATA_W-1:0]         resp_data2
);

    logic [IW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      win_idx;
    logic               win_any;
    logic               grant;
    logic [PREG_W-1:0]  win_rs1;
    logic [PREG_W-1:0]  win_rs2;
    logic [TAG_W-1:0]   win_tag;

    logic               s1_valid;
    logic [IW-1:0]      s1_id;
    logic [TAG_W-1:0]   s1_tag;
    logic [PREG_W-1:0]  s1_rs1;
    logic [PREG_W-1:0]  s1_rs2;
    logic               fwd1;
    logic               fwd2;
    logic [DATA_W-1:0]  fwd_data;

    rr_arbiter #(.N(NUM_REQ), .W(IW)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign grant     = win_any & ~flush & rst_n;
    assign req_ready = grant ? gnt : '0;

    always_comb begin
        win_rs1 = '0;
        win_rs2 = '0;
        win_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && gnt[i]) begin
                win_rs1 = req_rs1[i*PREG_W +: PREG_W];
                win_rs2 = req_rs2[i*PREG_W +: PREG_W];
                win_tag = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    assign rf_rd_addr1 = win_rs1;
    assign rf_rd_addr2 = win_rs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_tag   <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            fwd1     <= 1'b0;
            fwd2     <= 1'b0;
            fwd_data <= '0;
        end else begin
            s1_valid <= grant;
            if (grant) begin
                rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            s1_id    <= win_idx;
            s1_tag   <= win_tag;
            s1_rs1   <= win_rs1;
            s1_rs2   <= win_rs2;
            // The regfile returns pre-write data on a same-cycle write
            fwd1     <= wb_valid && wb_addr == win_rs1 && win_rs1 != '0;
            fwd2     <= wb_valid && wb_addr == win_rs2 && win_rs2 != '0;
            fwd_data <= wb_data;
        end
    end

    assign resp_valid = s1_valid & ~flush;
    assign resp_id    = s1_id;
    assign resp_tag   = s1_tag;

    always_comb begin
        resp_data1 = rf_rd_data1;
        if (s1_rs1 == '0)                    resp_data1 = '0;
        else if (wb_valid && wb_addr == s1_rs1) resp_data1 = wb_data;
        else if (fwd1)                       resp_data1 = fwd_data;
        resp_data2 = rf_rd_data2;
        if (s1_rs2 == '0)                    resp_data2 = '0;
        else if (wb_valid && wb_addr == s1_rs2) resp_data2 = wb_data;
        else if (fwd2)                       resp_data2 = fwd_data;
    end

endmodule

// File: tb/tb_phy_regfile_read_arbiter.sv
// Directed, table-driven bench for phy_regfile_read_arbiter.
module tb_phy_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  req_valid;
    logic [17:0] req_rs1;
    logic [17:0] req_rs2;
    logic [14:0] req_tag;
    logic [2:0]  req_ready;
    logic [5:0]  rf_rd_addr1;
    logic [5:0]  rf_rd_addr2;
    logic [31:0] rf_rd_data1;
    logic [31:0] rf_rd_data2;
    logic        wb_valid;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [4:0]  resp_tag;
    logic [31:0] resp_data1;
    logic [31:0] resp_data2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rf_rd_data1 <= mem[rf_rd_addr1];
        rf_rd_data2 <= mem[rf_rd_addr2];
    end

    phy_regfile_read_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_tag    (resp_tag),
        .resp_data1  (resp_data1),
        .resp_data2  (resp_data2)
    );

    typedef struct {
        logic [2:0]  v;
        logic        wbv;
        logic [5:0]  wba;
        logic [31:0] wbd;
        logic        fl;
        logic [2:0]  rdy;
        logic [5:0]  a1;
        logic [5:0]  a2;
        logic        rv;
        logic [1:0]  id;
        logic [4:0]  tag;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(
        logic [2:0] v, logic wbv, logic [5:0] wba, logic [31:0] wbd,
        logic fl, logic [2:0] rdy, logic [5:0] a1, logic [5:0] a2,
        logic rv, logic [1:0] id, logic [4:0] tag,
        logic [31:0] d1, logic [31:0] d2);
        vec_t r;
        r.v = v; r.wbv = wbv; r.wba = wba; r.wbd = wbd; r.fl = fl;
        r.rdy = rdy; r.a1 = a1; r.a2 = a2; r.rv = rv; r.id = id;
        r.tag = tag; r.d1 = d1; r.d2 = d2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        req_valid = x.v;
        wb_valid  = x.wbv;
        wb_addr   = x.wba;
        wb_data   = x.wbd;
        flush     = x.fl;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
        mem[0] = 32'hDEAD;
        mem[5] = 32'hA;
        mem[9] = 32'hB;
        mem[7] = 32'h11;

        // req0: 5/9 tag3, req1: 7/5 tag4, req2: 0/7 tag6
        req_rs1 = {6'd0, 6'd7, 6'd5};
        req_rs2 = {6'd7, 6'd5, 6'd9};
        req_tag = {5'd6, 5'd4, 5'd3};

        rst_n = 1'b0; flush = 1'b0; req_valid = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;

        //   v    wbv wba    wbd      fl rdy  a1 a2  rv id tag d1      d2
        vecs.push_back(mk(3'b000,0,0,0,      0,3'b000,0,0, 0,0,0,0,0));
        vecs.push_back(mk(3'b001,0,0,0,      0,3'b001,5,9, 0,0,0,0,0));
        vecs.push_back(mk(3'b000,0,0,0,      0,3'b000,0,0, 1,0,3,32'hA,32'hB));
        vecs.push_back(mk(3'b111,0,0,0,      0,3'b010,7,5, 0,0,0,0,0));
        vecs.push_back(mk(3'b111,0,0,0,      0,3'b100,0,7, 1,1,4,32'h11,32'hA));
        vecs.push_back(mk(3'b111,0,0,0,      0,3'b001,5,9, 1,2,6,32'h0,32'h11));
        vecs.push_back(mk(3'b111,0,0,0,      0,3'b010,7,5, 1,0,3,32'hA,32'hB));
        vecs.push_back(mk(3'b000,0,0,0,      0,3'b000,0,0, 1,1,4,32'h11,32'hA));
        vecs.push_back(mk(3'b010,1,7,32'h55, 0,3'b010,7,5, 0,0,0,0,0));
        vecs.push_back(mk(3'b000,0,0,0,      0,3'b000,0,0, 1,1,4,32'h55,32'hA));
        vecs.push_back(mk(3'b010,0,0,0,      0,3'b010,7,5, 0,0,0,0,0));
        vecs.push_back(mk(3'b000,1,7,32'h66, 0,3'b000,0,0, 1,1,4,32'h66,32'hA));
        vecs.push_back(mk(3'b010,1,5,32'h77, 0,3'b010,7,5, 0,0,0,0,0));
        vecs.push_back(mk(3'b000,0,0,0,      0,3'b000,0,0, 1,1,4,32'h11,32'h77));
        vecs.push_back(mk(3'b010,1,7,32'h55, 0,3'b010,7,5, 0,0,0,0,0));
        vecs.push_back(mk(3'b000,1,7,32'h99, 0,3'b000,0,0, 1,1,4,32'h99,32'hA));
        vecs.push_back(mk(3'b001,0,0,0,      0,3'b001,5,9, 0,0,0,0,0));
        vecs.push_back(mk(3'b000,0,0,0,      1,3'b000,0,0, 0,0,0,0,0));
        vecs.push_back(mk(3'b011,0,0,0,      1,3'b000,0,0, 0,0,0,0,0));
        vecs.push_back(mk(3'b011,0,0,0,      0,3'b010,7,5, 0,0,0,0,0));
        vecs.push_back(mk(3'b011,0,0,0,      0,3'b001,5,9, 1,1,4,32'h11,32'hA));
        vecs.push_back(mk(3'b000,0,0,0,      0,3'b000,0,0, 1,0,3,32'hA,32'hB));

        // Reset state, then idle for 10 cycles
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_ready", 32'(req_ready), 0);
            chk("idle_resp_valid", 32'(resp_valid), 0);
            chk("idle_addr1", 32'(rf_rd_addr1), 0);
            chk("idle_addr2", 32'(rf_rd_addr2), 0);
        end

        foreach (vecs[k]) begin
            @(posedge clk); #1 drive(vecs[k]);
            @(negedge clk);
            chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].rdy));
            chk($sformatf("v%0d_addr1", k), 32'(rf_rd_addr1), 32'(vecs[k].a1));
            chk($sformatf("v%0d_addr2", k), 32'(rf_rd_addr2), 32'(vecs[k].a2));
            chk($sformatf("v%0d_rvalid", k), 32'(resp_valid), 32'(vecs[k].rv));
            if (vecs[k].rv) begin
                chk($sformatf("v%0d_id", k), 32'(resp_id), 32'(vecs[k].id));
                chk($sformatf("v%0d_tag", k), 32'(resp_tag), 32'(vecs[k].tag));
                chk($sformatf("v%0d_d1", k), resp_data1, vecs[k].d1);
                chk($sformatf("v%0d_d2", k), resp_data2, vecs[k].d2);
            end
        end

        // rs1=rs2=p0 with writebacks to p0 must still read zero (ptr=1)
        @(posedge clk); #1;
        req_rs1 = {6'd0, 6'd7, 6'd5};
        req_rs2 = {6'd0, 6'd5, 6'd9};
        req_valid = 3'b100; wb_valid = 1'b1; wb_addr = 6'd0; wb_data = 32'h33;
        @(negedge clk);
        chk("p0_ready", 32'(req_ready), 32'b100);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("p0_rvalid", 32'(resp_valid), 1);
        chk("p0_tag", 32'(resp_tag), 6);
        chk("p0_d1", resp_data1, 0);
        chk("p0_d2", resp_data2, 0);
        wb_valid = 1'b0;

        // Reset mid-flight: granted read must never respond (ptr=0)
        @(posedge clk); #1 req_valid = 3'b001;
        @(negedge clk);
        chk("mr_ready", 32'(req_ready), 32'b001);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mr_ready_rst", 32'(req_ready), 0);
        chk("mr_rvalid_rst", 32'(resp_valid), 0);
        @(posedge clk); #1 rst_n = 1'b1; req_valid = '0;
        @(negedge clk);
        chk("mr_rvalid_after", 32'(resp_valid), 0);
        chk("mr_ready_after", 32'(req_ready), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
